// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the FIFO access scheduler.
package fifo_sched_pkg;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefFifoDepth = 16;
  localparam int unsigned DefDelayWidth = 8;

  // Read-side pacer states.
  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRead,
    StCapt,
    StHold
  } pacer_state_e;

endpackage

// File: rtl/fifo_access_scheduler_if.sv
// Producer, FIFO, configuration and paced-output signals of the scheduler.
interface fifo_access_scheduler_if
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter int unsigned DELAY_WIDTH = DefDelayWidth
);
  localparam int unsigned OccWidth = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_read_en;
  logic [DATA_WIDTH-1:0]         fifo_data_out;
  logic                          cfg_enable;
  logic [DELAY_WIDTH-1:0]        cfg_delay;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_ready;
  logic [OccWidth-1:0]           occupancy;

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, fifo_full, fifo_empty, fifo_data_out,
    input  cfg_enable, cfg_delay, out_ready,
    output req_ready, fifo_write_en, fifo_data_in, fifo_read_en,
    output out_valid, out_data, occupancy
  );

  // Environment side: producers, FIFO, consumer.
  modport master (
    output req_valid, req_data, fifo_full, fifo_empty, fifo_data_out,
    output cfg_enable, cfg_delay, out_ready,
    input  req_ready, fifo_write_en, fifo_data_in, fifo_read_en,
    input  out_valid, out_data, occupancy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int unsigned PtrWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrWidth-1:0] ptr_q, ptr_d, winner;
  logic                found;
  int                  idx;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    grant  = '0;
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PtrWidth'(idx);
      end
    end
    if (found) grant[winner] = 1'b1;
  end

  // Pointer moves past the winner only when the grant is actually used.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = PtrWidth'((int'(winner) + 1) % int'(NUM_REQ));
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Shares one FIFO among NUM_REQ producers and paces reads with a hold-off.
module fifo_access_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth,
  parameter int unsigned DELAY_WIDTH = DefDelayWidth
) (
  input logic                     clk,
  input logic                     rst,
  fifo_access_scheduler_if.slave  bus
);
  localparam int unsigned OccWidth = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OccWidth-1:0] DepthVal = OccWidth'(FIFO_DEPTH);

  logic [OccWidth-1:0]    occ_q;
  pacer_state_e           state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [NUM_REQ-1:0]     grant;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   credit, wr, rd;

  // Credit uses the local count so flag latency in the FIFO cannot overflow it.
  assign credit = !rst && (occ_q < DepthVal) && !bus.fifo_full;
  assign wr     = credit && (|bus.req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (wr),
    .grant   (grant)
  );

  // Select the winning producer's word (grant is one-hot).
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready     = credit ? grant : '0;
  assign bus.fifo_write_en = wr;
  assign bus.fifo_data_in  = wr_data;
  assign bus.fifo_read_en  = rd;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.occupancy     = occ_q;

  // Local occupancy: simultaneous write and read cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (wr && !rd && occ_q != DepthVal) begin
      occ_q <= occ_q + 1'b1;
    end else if (rd && !wr && occ_q != '0) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  // Pacer next-state: hold-off, one-cycle read, capture, hold until accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_enable && occ_q != '0 && !bus.fifo_empty) begin
          cnt_d   = bus.cfg_delay;
          state_d = (bus.cfg_delay == '0) ? StRead : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DELAY_WIDTH'(1)) state_d = StRead;
      end
      StRead: begin
        rd      = 1'b1;
        state_d = StCapt;
      end
      StCapt: begin
        out_data_d  = bus.fifo_data_out;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pacer state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Scoreboard bench: behavioural FIFO, arbitration/occupancy model, paced-output checks.
module tb_fifo_access_scheduler;
  localparam int NR    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int DLW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_access_scheduler_if #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DELAY_WIDTH(DLW)
  ) bus ();

  fifo_access_scheduler #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DELAY_WIDTH(DLW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Attached FIFO: data_out is registered on the read strobe.
  logic [DW-1:0] fq[$];
  int            fifo_cnt = 0;
  logic [DW-1:0] fifo_dout = '0;
  assign bus.fifo_full     = (fifo_cnt >= DEPTH);
  assign bus.fifo_empty    = (fifo_cnt == 0);
  assign bus.fifo_data_out = fifo_dout;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_cnt  <= 0;
      fifo_dout <= '0;
    end else begin
      if (bus.fifo_read_en) begin
        if (fq.size() > 0) fifo_dout <= fq.pop_front();
        else               fifo_dout <= '0;
      end
      if (bus.fifo_write_en) fq.push_back(bus.fifo_data_in);
      fifo_cnt <= fq.size();
    end
  end

  // Reference model state and scoreboard.
  int            m_ptr = 0;
  int            m_occ = 0;
  logic [DW-1:0] sb[$];
  int            grant_cnt[NR];
  int            hs_q[$];
  int            read_cnt  = 0;
  int            write_cnt = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  bit            mon_credit, mon_found;
  int            mon_win;
  logic [NR-1:0] mon_exp_ready;
  logic [DW-1:0] mon_exp_data;

  // Monitor: compare every cycle against the model, then advance the model.
  always @(negedge clk) begin : monitor
    check("occupancy", 32'(bus.occupancy), m_occ);
    mon_credit = !rst && (m_occ < DEPTH) && (fifo_cnt < DEPTH);
    mon_found  = 1'b0;
    mon_win    = 0;
    for (int k = 0; k < NR; k++) begin
      if (!mon_found && bus.req_valid[(m_ptr + k) % NR]) begin
        mon_found = 1'b1;
        mon_win   = (m_ptr + k) % NR;
      end
    end
    mon_exp_ready = '0;
    if (mon_credit && mon_found) mon_exp_ready[mon_win] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(mon_exp_ready));
    check("fifo_write_en", 32'(bus.fifo_write_en), 32'(mon_credit && mon_found));
    mon_exp_data = bus.req_data[mon_win*DW +: DW];
    if (mon_credit && mon_found) check("fifo_data_in", 32'(bus.fifo_data_in), 32'(mon_exp_data));
    if (bus.fifo_read_en) begin
      read_cnt++;
      check("read_has_data", 32'(m_occ > 0 && fifo_cnt > 0), 1);
    end
    if (prev_hold) begin
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_data", 32'(bus.out_data), 32'(prev_data));
    end
    prev_hold = bus.out_valid && !bus.out_ready && !rst;
    prev_data = bus.out_data;
    if (bus.out_valid && bus.out_ready && !rst) begin
      hs_q.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got data %0d expected no output (cycle %0d)",
                 bus.out_data, cyc);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(sb.pop_front()));
      end
    end
    if (rst) begin
      m_occ     = 0;
      m_ptr     = 0;
      prev_hold = 1'b0;
      sb.delete();
    end else begin
      if (mon_credit && mon_found) begin
        sb.push_back(mon_exp_data);
        m_ptr = (mon_win + 1) % NR;
        grant_cnt[mon_win]++;
        write_cnt++;
      end
      m_occ = m_occ + ((mon_credit && mon_found) ? 1 : 0) - (bus.fifo_read_en ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int ch, input logic [DW-1:0] d, output int t_edge);
    int n = 0;
    bus.req_valid = '0;
    bus.req_valid[ch] = 1'b1;
    bus.req_data[ch*DW +: DW] = d;
    @(negedge clk);
    while (!bus.req_ready[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("write_granted", 32'(bus.req_ready[ch]), 1);
    t_edge = cyc + 1;
    tick();
    bus.req_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    int quiet = 0;
    bus.req_valid  = '0;
    bus.cfg_enable = 1'b1;
    bus.out_ready  = 1'b1;
    while (quiet < 3 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.occupancy == 0 && !bus.out_valid && sb.size() == 0) quiet++;
      else quiet = 0;
    end
    check("drain_done", quiet, 3);
    check("drain_sb_empty", sb.size(), 0);
    tick();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t, n, snap;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.cfg_enable = 1'b0;
    bus.cfg_delay  = '0;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_occupancy", 32'(bus.occupancy), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_read_en", 32'(bus.fifo_read_en), 0);
    tick();

    // All producers valid, pacing off: fill exactly to depth in round-robin order.
    write_cnt = 0;
    bus.req_data  = 16'h4321;
    bus.req_valid = 4'b1111;
    repeat (20) tick();
    check("fill_writes", write_cnt, DEPTH);
    check("fill_ready_low", 32'(bus.req_ready), 0);
    check("fill_occupancy", 32'(bus.occupancy), DEPTH);
    for (int i = 0; i < NR; i++) check("fill_grants_per_ch", grant_cnt[i], DEPTH / NR);

    // Full FIFO: one read frees a slot, the write is granted the cycle after.
    bus.cfg_delay  = '0;
    bus.out_ready  = 1'b0;
    bus.cfg_enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.fifo_read_en && n < 50);
    check("full_read_seen", 32'(bus.fifo_read_en), 1);
    check("full_no_write_on_read", 32'(bus.fifo_write_en), 0);
    @(negedge clk);
    check("full_write_after_read", 32'(bus.fifo_write_en), 1);
    repeat (3) @(negedge clk);
    check("full_occupancy", 32'(bus.occupancy), DEPTH);
    tick();
    drain();

    // Two alternating producers; idle channels never granted.
    bus.cfg_enable = 1'b0;
    for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
    bus.req_data  = 16'h9876;
    bus.req_valid = 4'b0101;
    repeat (8) tick();
    bus.req_valid = '0;
    check("alt_ch0", grant_cnt[0], 4);
    check("alt_ch1_idle", grant_cnt[1], 0);
    check("alt_ch2", grant_cnt[2], 4);
    check("alt_ch3_idle", grant_cnt[3], 0);
    drain();

    // Latency with a 5-cycle hold-off.
    bus.cfg_delay  = 8'd5;
    bus.cfg_enable = 1'b1;
    bus.out_ready  = 1'b1;
    write_word(0, 4'hA, t);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.fifo_read_en && n < 100);
    check("lat_read_seen", 32'(bus.fifo_read_en), 1);
    check("lat_read_cycle", cyc - t, 6);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
    check("lat_valid_cycle", cyc - t, 8);
    check("lat_data", 32'(bus.out_data), 32'hA);
    repeat (2) @(negedge clk);
    check("lat_occupancy", 32'(bus.occupancy), 0);
    tick();

    // Zero hold-off with a stalled consumer, then back-to-back outputs.
    bus.cfg_delay = '0;
    bus.out_ready = 1'b0;
    write_word(0, 4'h1, t);
    write_word(0, 4'h2, t);
    write_word(0, 4'h3, t);
    hs_q.delete();
    repeat (10) tick();
    check("stall_valid", 32'(bus.out_valid), 1);
    check("stall_data", 32'(bus.out_data), 1);
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("burst_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("burst_gap_1", hs_q[1] - hs_q[0], 4);
      check("burst_gap_2", hs_q[2] - hs_q[1], 4);
    end
    drain();

    // Reset during the hold-off aborts the transaction.
    bus.cfg_enable = 1'b0;
    write_word(1, 4'h7, t);
    write_word(1, 4'h8, t);
    write_word(1, 4'h9, t);
    bus.cfg_delay  = 8'd20;
    bus.cfg_enable = 1'b1;
    repeat (4) tick();
    check("rstw_occupancy", 32'(bus.occupancy), 3);
    snap = read_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstw_req_ready", 32'(bus.req_ready), 0);
    check("rstw_write_en", 32'(bus.fifo_write_en), 0);
    check("rstw_read_en", 32'(bus.fifo_read_en), 0);
    check("rstw_out_valid", 32'(bus.out_valid), 0);
    check("rstw_out_data", 32'(bus.out_data), 0);
    check("rstw_occupancy0", 32'(bus.occupancy), 0);
    repeat (30) tick();
    check("rstw_no_read", read_cnt - snap, 0);

    // Randomized traffic against the model and scoreboard.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid  = NR'($urandom);
      bus.req_data   = (NR*DW)'($urandom);
      bus.out_ready  = ($urandom % 4) != 0;
      bus.cfg_enable = ($urandom % 8) != 0;
      bus.cfg_delay  = DLW'($urandom_range(0, 3));
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_access_scheduler.md
Name: fifo_access_scheduler

Overview:
Shares one single-port-per-side FIFO instance (default 16 entries of 4 bits) among NUM_REQ producers and paces reads out of it.
- Write side: round-robin arbiter. Grants at most one producer per cycle and drives the FIFO write interface.
- Read side: delay-pacing FSM. Each entry is released only after a programmable hold-off, then presented on a valid/ready output.
- The block keeps its own occupancy count, so FIFO flag latency never causes overflow or underflow.

Parameters:
NUM_REQ, 4, number of producer channels
DATA_WIDTH, 4, FIFO word width
FIFO_DEPTH, 16, entries in the attached FIFO
DELAY_WIDTH, 8, width of cfg_delay and the hold-off counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-producer data valid
req_data  input  NUM_REQ*DATA_WIDTH  producer data; channel i is bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  one-hot grant; transfer happens when valid and ready are both high
fifo_write_en  output  1  FIFO write strobe
fifo_data_in  output  DATA_WIDTH  FIFO write data
fifo_full  input  1  FIFO full flag (secondary gate)
fifo_empty  input  1  FIFO empty flag (secondary gate)
fifo_read_en  output  1  FIFO read strobe
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_en
cfg_enable  input  1  read pacing enable
cfg_delay  input  DELAY_WIDTH  hold-off cycles before each read
out_valid  output  1  paced output valid
out_data  output  DATA_WIDTH  paced output data
out_ready  input  1  consumer ready
occupancy  output  $clog2(FIFO_DEPTH)+1  local entry count

Behaviour:
- Reset: all of the following are 0: occupancy, rr pointer, req_ready, fifo_write_en, fifo_read_en, out_valid, out_data. FSM goes to IDLE. Reset mid-transaction aborts it; no output is produced.
- Write credit: occupancy < FIFO_DEPTH and !fifo_full.
- Arbitration (combinational):
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first channel with req_valid high wins.
  - With credit, req_ready = that channel's one-hot bit, fifo_write_en = 1, fifo_data_in = the winner's data.
  - No credit, or no valid channel: req_ready = 0, fifo_write_en = 0.
  - After a grant, rr_ptr <= winner + 1 (mod NUM_REQ). Otherwise it holds.
- Occupancy update:
  - +1 on write only; -1 on fifo_read_en only.
  - Write and read in the same cycle: unchanged.
  - Never exceeds FIFO_DEPTH and never goes below 0.
- Pacer FSM states: IDLE, WAIT, READ, CAPT, HOLD.
  - IDLE: if cfg_enable && occupancy > 0 && !fifo_empty, load cnt <= cfg_delay. Go to READ if cfg_delay == 0, else WAIT. cfg_delay is sampled only at this transition.
  - WAIT: cnt decrements each cycle; when cnt == 1, go to READ.
  - READ: fifo_read_en = 1 for exactly one cycle, then CAPT.
  - CAPT: out_data <= fifo_data_out, out_valid <= 1, then HOLD.
  - HOLD: out_valid held and out_data stable until out_ready. On that handshake, out_valid <= 0 and the FSM returns to IDLE.
- Latency: write accepted at edge T, delay D.
  - fifo_read_en is high in cycle T+1+D.
  - out_valid rises at edge T+3+D.
  - D = 0 gives a read in cycle T+1.
- Throughput: at most one output per D+4 cycles.
- cfg_enable deasserted mid-transaction: the current item completes. No new read starts until it is reasserted. Writes are unaffected.
- Simultaneous write and read with the FIFO full: the write is not granted in that cycle (credit is computed on the current occupancy).

Decomposition:
- Package fifo_sched_pkg: the pacer state enum (IDLE, WAIT, READ, CAPT, HOLD) and the default parameter constants.
- Sub-module rr_arbiter (NUM_REQ): inputs req and advance; outputs one-hot grant; owns rr_ptr.
- Pacer FSM and occupancy counter live in the top module.

Test Plan:
- Reset, then all req_valid = 4'b1111 held, cfg_enable = 0 -> grants in order 0,1,2,3,0,... one per cycle. Exactly 16 writes occur, then req_ready = 0 with occupancy = 16.
- req_valid = 4'b0101 -> grants alternate 0,2,0,2. An idle channel never receives req_ready.
- Write 4'hA, cfg_delay = 5, cfg_enable = 1, out_ready = 1 -> fifo_read_en in cycle T+6, out_valid at T+8 with out_data = 4'hA. Occupancy returns to 0.
- cfg_delay = 0, three words 1,2,3 written, out_ready held low for 10 cycles, then high -> out_data = 1 is stable throughout the stall. Outputs 1,2,3 arrive in order, 4 cycles apart.
- FIFO full (occupancy = 16), pacer reads while a producer is valid -> the write is granted the cycle after fifo_read_en. Occupancy never exceeds 16.
- Assert rst during WAIT with occupancy = 3 -> all outputs are 0 the next cycle and the FSM is in IDLE. No fifo_read_en is issued.
